// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer between an ADC sample stream and an xfft core
//
// Purpose: per frame, configures the core (runtime length, direction, scaling), converts
// ADC samples to complex core format, zero-pads short records, truncates long ones,
// generates the core tlast and forwards the core result stream with frame accounting.
//
// Ports:
//   aclk, aresetn                      clock, synchronous active-low reset
//   start, abort                       frame control pulses
//   cfg_log2_len/fwd_inv/scale_sch     frame configuration, latched at start
//   s_axis_*                           ADC sample stream in
//   m_cfg_*                            core configuration channel
//   m_core_*                           core data in, {imag, real}
//   s_res_* / m_axis_*                 core result stream, forwarded combinationally
//   busy, frame_done, frame_count      frame status
//   err_len, err_trunc                 sticky error flags

module fft_frame_ctrl #(
    parameter int MAX_LOG2_LEN = 13,
    parameter int IN_WIDTH     = 16,
    parameter int ADC_BITS     = 8,
    parameter int CORE_WIDTH   = 16,
    parameter int SCH_WIDTH    = 14,
    parameter int CFG_SETTLE   = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [4:0]              cfg_log2_len,
    input  logic                    cfg_fwd_inv,
    input  logic [SCH_WIDTH-1:0]    cfg_scale_sch,
    input  logic [IN_WIDTH-1:0]     s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [23:0]             m_cfg_tdata,
    output logic                    m_cfg_tvalid,
    input  logic                    m_cfg_tready,
    output logic [2*CORE_WIDTH-1:0] m_core_tdata,
    output logic                    m_core_tvalid,
    output logic                    m_core_tlast,
    input  logic                    m_core_tready,
    input  logic [2*CORE_WIDTH-1:0] s_res_tdata,
    input  logic                    s_res_tvalid,
    input  logic                    s_res_tlast,
    output logic                    s_res_tready,
    output logic [2*CORE_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_len,
    output logic                    err_trunc,
    output logic [15:0]             frame_count
);

    localparam int CNT_W = MAX_LOG2_LEN + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_SETTLE, S_LOAD, S_PAD, S_FLUSH, S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4:0]              r_len;
    logic                    r_fwd;
    logic [SCH_WIDTH-1:0]    r_sch;
    logic [CNT_W-1:0]        r_cnt;
    logic [7:0]              r_settle;
    logic [2*CORE_WIDTH-1:0] r_core_tdata;
    logic                    r_core_tvalid;
    logic                    r_core_tlast;
    logic                    r_frame_done;
    logic                    r_err_len;
    logic                    r_err_trunc;
    logic [15:0]             r_frame_count;

    logic                    w_abort;
    logic                    w_start;
    logic                    w_core_free;
    logic                    w_in_hs;
    logic                    w_load;
    logic                    w_cnt_last;
    logic                    w_res_last_hs;
    logic [CNT_W-1:0]        w_last_idx;
    logic [4:0]              w_clamp_len;
    logic                    w_clamped;
    logic [CORE_WIDTH-1:0]   w_real;
    logic [2*CORE_WIDTH-1:0] w_core_word;
    logic                    w_unused_tdata;

    // Abort only matters while a frame is in flight; it also suppresses a coincident start.
    assign w_abort       = abort && (r_state != S_IDLE);
    assign w_start       = start && !abort && (r_state == S_IDLE);
    // Single output register: it can take a new beat when empty or being emptied this cycle.
    assign w_core_free   = !r_core_tvalid || m_core_tready;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_load        = (r_state == S_LOAD && w_in_hs) ||
                           (r_state == S_PAD && w_core_free && !abort);
    assign w_last_idx    = CNT_W'((32'd1 << r_len) - 32'd1);
    assign w_cnt_last    = (r_cnt == w_last_idx);
    assign w_res_last_hs = s_res_tvalid && m_axis_tready && s_res_tlast;

    assign w_real         = {{(CORE_WIDTH-ADC_BITS){s_axis_tdata[IN_WIDTH-1]}},
                             s_axis_tdata[IN_WIDTH-1 -: ADC_BITS]};
    assign w_core_word    = {{CORE_WIDTH{1'b0}}, w_real};
    assign w_unused_tdata = ^s_axis_tdata[IN_WIDTH-ADC_BITS-1:0];

    always_comb begin
        w_clamp_len = cfg_log2_len;
        w_clamped   = 1'b0;
        if (cfg_log2_len < 5'd3) begin
            w_clamp_len = 5'd3;
            w_clamped   = 1'b1;
        end else if (cfg_log2_len > 5'(MAX_LOG2_LEN)) begin
            w_clamp_len = 5'(MAX_LOG2_LEN);
            w_clamped   = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_CONFIG;
            S_CONFIG: if (m_cfg_tready) w_next = S_SETTLE;
            S_SETTLE: if (r_settle == 8'(CFG_SETTLE - 1)) w_next = S_LOAD;
            S_LOAD: begin
                if (w_in_hs) begin
                    if (w_cnt_last) begin
                        w_next = s_axis_tlast ? S_DRAIN : S_FLUSH;
                    end else if (s_axis_tlast) begin
                        w_next = S_PAD;
                    end
                end
            end
            S_PAD:    if (w_load && w_cnt_last) w_next = S_DRAIN;
            S_FLUSH:  if (w_in_hs && s_axis_tlast) w_next = S_DRAIN;
            S_DRAIN:  if (w_res_last_hs) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        s_axis_tready = 1'b0;
        m_cfg_tvalid  = 1'b0;
        case (r_state)
            S_CONFIG: m_cfg_tvalid  = 1'b1;
            S_LOAD:   s_axis_tready = w_core_free && !abort;
            S_FLUSH:  s_axis_tready = !abort;
            default:  s_axis_tready = 1'b0;
        endcase
    end

    always_comb begin
        m_cfg_tdata                  = '0;
        m_cfg_tdata[4:0]             = r_len;
        m_cfg_tdata[8]               = r_fwd;
        m_cfg_tdata[9 +: SCH_WIDTH]  = r_sch;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_len         <= '0;
            r_fwd         <= 1'b0;
            r_sch         <= '0;
            r_cnt         <= '0;
            r_settle      <= '0;
            r_core_tdata  <= '0;
            r_core_tvalid <= 1'b0;
            r_core_tlast  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_trunc   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;

            if (m_core_tready) begin
                r_core_tvalid <= 1'b0;
            end
            if (w_load) begin
                r_core_tdata  <= (r_state == S_PAD) ? '0 : w_core_word;
                r_core_tlast  <= w_cnt_last;
                r_core_tvalid <= 1'b1;
                r_cnt         <= r_cnt + 1'b1;
            end

            if (r_state == S_SETTLE) begin
                r_settle <= r_settle + 8'd1;
            end else begin
                r_settle <= '0;
            end

            if (w_start) begin
                r_len <= w_clamp_len;
                r_fwd <= cfg_fwd_inv;
                r_sch <= cfg_scale_sch;
                r_cnt <= '0;
                if (w_clamped) begin
                    r_err_len <= 1'b1;
                end
            end

            // Nth sample without tlast: the rest of the record is discarded.
            if (r_state == S_LOAD && w_in_hs && w_cnt_last && !s_axis_tlast) begin
                r_err_trunc <= 1'b1;
            end

            if (r_state == S_DRAIN && w_res_last_hs && !abort) begin
                r_frame_done  <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (w_abort) begin
                r_core_tvalid <= 1'b0;
                r_core_tlast  <= 1'b0;
            end
        end
    end

    assign m_core_tdata  = r_core_tdata;
    assign m_core_tvalid = r_core_tvalid;
    assign m_core_tlast  = r_core_tlast;

    assign m_axis_tdata  = s_res_tdata;
    assign m_axis_tvalid = s_res_tvalid;
    assign m_axis_tlast  = s_res_tlast;
    assign s_res_tready  = m_axis_tready;

    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign err_len     = r_err_len;
    assign err_trunc   = r_err_trunc;
    assign frame_count = r_frame_count;

endmodule
